// File: rtl/decode_exec_reg_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Widths and types shared by decode, the decode/execute register and execute.
//   ctrl_t is the decoded control bundle so both sides of the register agree
//   on one layout. act_e names the single action the register takes per edge.
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DW  = 32;   // operand / immediate / PC width
   localparam int AW  = 5;    // register address width
   localparam int OPW = 4;    // ALU opcode width

   localparam logic [OPW-1:0] ALU_NOP = 4'h0;

   typedef struct packed {
      logic [AW-1:0]  regWa;
      logic           regWe;
      logic           isLoad;
      logic           isStore;
      logic [OPW-1:0] aluOp;
      logic           aluSrc;
   } ctrl_t;

   // Control of an empty slot: no write, no memory access, ALU does nothing.
   localparam ctrl_t CTRL_NOP = '{regWa: '0, regWe: 1'b0, isLoad: 1'b0,
                                  isStore: 1'b0, aluOp: ALU_NOP, aluSrc: 1'b0};

   typedef enum logic [1:0] {
      ACT_LOAD   = 2'd0,
      ACT_HOLD   = 2'd1,
      ACT_BUBBLE = 2'd2
   } act_e;

endpackage

// File: rtl/decode_exec_reg_if.sv
// ----------------------------------------------------------------------------
// decode_exec_reg_if
//   Bundle between decode/pause unit, the decode/execute register and execute.
//   i_* : forwarded operands, immediate, PC, decoded control, pause/flush/stall
//   o_* : registered slot contents, valid flag and bubble counter
//   Modports:
//     slave  - the pipeline register (consumes i_*, produces o_*)
//     master - the upstream/downstream environment (drives i_*, observes o_*)
// ----------------------------------------------------------------------------
interface decode_exec_reg_if #(
   parameter int DW  = cpu_pkg::DW,
   parameter int AW  = cpu_pkg::AW,
   parameter int OPW = cpu_pkg::OPW
);
   logic [DW-1:0]  i_DecodeExecReg_rd1;
   logic [DW-1:0]  i_DecodeExecReg_rd2;
   logic [DW-1:0]  i_DecodeExecReg_imm;
   logic [DW-1:0]  i_DecodeExecReg_pc;
   logic [AW-1:0]  i_DecodeExecReg_regWa;
   logic           i_DecodeExecReg_regWe;
   logic           i_DecodeExecReg_isLoad;
   logic           i_DecodeExecReg_isStore;
   logic [OPW-1:0] i_DecodeExecReg_aluOp;
   logic           i_DecodeExecReg_aluSrc;
   logic           i_DecodeExecReg_pause;
   logic           i_DecodeExecReg_flush;
   logic           i_DecodeExecReg_stall;

   logic [DW-1:0]  o_DecodeExecReg_rd1;
   logic [DW-1:0]  o_DecodeExecReg_rd2;
   logic [DW-1:0]  o_DecodeExecReg_imm;
   logic [DW-1:0]  o_DecodeExecReg_pc;
   logic [AW-1:0]  o_DecodeExecReg_regWa;
   logic           o_DecodeExecReg_regWe;
   logic           o_DecodeExecReg_isLoad;
   logic           o_DecodeExecReg_isStore;
   logic [OPW-1:0] o_DecodeExecReg_aluOp;
   logic           o_DecodeExecReg_aluSrc;
   logic           o_DecodeExecReg_valid;
   logic [31:0]    o_DecodeExecReg_bubbleCnt;

   modport slave (
      input  i_DecodeExecReg_rd1, i_DecodeExecReg_rd2, i_DecodeExecReg_imm,
             i_DecodeExecReg_pc, i_DecodeExecReg_regWa, i_DecodeExecReg_regWe,
             i_DecodeExecReg_isLoad, i_DecodeExecReg_isStore,
             i_DecodeExecReg_aluOp, i_DecodeExecReg_aluSrc,
             i_DecodeExecReg_pause, i_DecodeExecReg_flush, i_DecodeExecReg_stall,
      output o_DecodeExecReg_rd1, o_DecodeExecReg_rd2, o_DecodeExecReg_imm,
             o_DecodeExecReg_pc, o_DecodeExecReg_regWa, o_DecodeExecReg_regWe,
             o_DecodeExecReg_isLoad, o_DecodeExecReg_isStore,
             o_DecodeExecReg_aluOp, o_DecodeExecReg_aluSrc,
             o_DecodeExecReg_valid, o_DecodeExecReg_bubbleCnt
   );

   modport master (
      output i_DecodeExecReg_rd1, i_DecodeExecReg_rd2, i_DecodeExecReg_imm,
             i_DecodeExecReg_pc, i_DecodeExecReg_regWa, i_DecodeExecReg_regWe,
             i_DecodeExecReg_isLoad, i_DecodeExecReg_isStore,
             i_DecodeExecReg_aluOp, i_DecodeExecReg_aluSrc,
             i_DecodeExecReg_pause, i_DecodeExecReg_flush, i_DecodeExecReg_stall,
      input  o_DecodeExecReg_rd1, o_DecodeExecReg_rd2, o_DecodeExecReg_imm,
             o_DecodeExecReg_pc, o_DecodeExecReg_regWa, o_DecodeExecReg_regWe,
             o_DecodeExecReg_isLoad, o_DecodeExecReg_isStore,
             o_DecodeExecReg_aluOp, o_DecodeExecReg_aluSrc,
             o_DecodeExecReg_valid, o_DecodeExecReg_bubbleCnt
   );
endinterface

// File: rtl/decode_exec_reg_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   W-bit up counter that sticks at all-ones.
//   clk   : rising-edge clock
//   rstn  : synchronous active-low clear
//   inc_i : count this edge
//   cnt_o : registered count
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/decode_exec_reg.sv
// ----------------------------------------------------------------------------
// decode_exec_reg
//   Decode/execute pipeline register behind the pause (hazard/forwarding) unit.
//   Per edge exactly one action, highest priority first:
//     reset -> clear, flush -> bubble, stall -> hold, pause -> bubble, else load.
//   Ports:
//     clk  : rising-edge clock
//     rstn : synchronous active-low reset
//     dx   : decode_exec_reg_if.slave (inputs from decode, registered outputs)
//   Optional feature (macro DECODE_EXEC_REG_PERF_EN): saturating count of
//   bubble edges on o_DecodeExecReg_bubbleCnt; otherwise that port is 0.
// ----------------------------------------------------------------------------
module decode_exec_reg
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   decode_exec_reg_if.slave dx
);
   act_e          act;
   ctrl_t         ctrl_in, ctrl_d, ctrl_q;
   logic [DW-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q, pc_d, pc_q;
   logic          valid_d, valid_q;

   // Flush outranks stall so a squashed slot can never sit frozen and retire.
   // Pause is only seen when execute is accepting.
   always_comb begin
      act = ACT_LOAD;
      if      (dx.i_DecodeExecReg_flush) act = ACT_BUBBLE;
      else if (dx.i_DecodeExecReg_stall) act = ACT_HOLD;
      else if (dx.i_DecodeExecReg_pause) act = ACT_BUBBLE;
   end

   // r0 writes are never advertised, so hazard logic cannot match on r0.
   always_comb begin
      ctrl_in = '{regWa:   dx.i_DecodeExecReg_regWa,
                  regWe:   dx.i_DecodeExecReg_regWe && (dx.i_DecodeExecReg_regWa != '0),
                  isLoad:  dx.i_DecodeExecReg_isLoad,
                  isStore: dx.i_DecodeExecReg_isStore,
                  aluOp:   dx.i_DecodeExecReg_aluOp,
                  aluSrc:  dx.i_DecodeExecReg_aluSrc};
   end

   always_comb begin
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      case (act)
         ACT_LOAD: begin
            rd1_d   = dx.i_DecodeExecReg_rd1;
            rd2_d   = dx.i_DecodeExecReg_rd2;
            imm_d   = dx.i_DecodeExecReg_imm;
            pc_d    = dx.i_DecodeExecReg_pc;
            ctrl_d  = ctrl_in;
            valid_d = 1'b1;
         end
         ACT_BUBBLE: begin
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            pc_d    = '0;
            ctrl_d  = CTRL_NOP;
            valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         ctrl_q  <= CTRL_NOP;
         valid_q <= 1'b0;
      end else begin
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
      end
   end

   assign dx.o_DecodeExecReg_rd1     = rd1_q;
   assign dx.o_DecodeExecReg_rd2     = rd2_q;
   assign dx.o_DecodeExecReg_imm     = imm_q;
   assign dx.o_DecodeExecReg_pc      = pc_q;
   assign dx.o_DecodeExecReg_regWa   = ctrl_q.regWa;
   assign dx.o_DecodeExecReg_regWe   = ctrl_q.regWe;
   assign dx.o_DecodeExecReg_isLoad  = ctrl_q.isLoad;
   assign dx.o_DecodeExecReg_isStore = ctrl_q.isStore;
   assign dx.o_DecodeExecReg_aluOp   = ctrl_q.aluOp;
   assign dx.o_DecodeExecReg_aluSrc  = ctrl_q.aluSrc;
   assign dx.o_DecodeExecReg_valid   = valid_q;

`ifdef DECODE_EXEC_REG_PERF_EN
   logic [31:0] bubble_cnt;

   sat_counter #(.W(32)) u_bubble_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc_i (act == ACT_BUBBLE),
      .cnt_o (bubble_cnt)
   );

   assign dx.o_DecodeExecReg_bubbleCnt = bubble_cnt;
`else
   assign dx.o_DecodeExecReg_bubbleCnt = '0;
`endif

endmodule

// File: tb/tb_decode_exec_reg.sv
module tb_decode_exec_reg;
   import cpu_pkg::*;

   typedef struct packed {
      logic [31:0] rd1, rd2, imm, pc;
      logic [4:0]  wa;
      logic        we, ld, st;
      logic [3:0]  op;
      logic        src, valid;
      logic [31:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic rstn;
   int   errors = 0;
   int   checks = 0;

   decode_exec_reg_if dxif ();

   decode_exec_reg dut (.clk(clk), .rstn(rstn), .dx(dxif.slave));

   always #5 clk = ~clk;

   obs_t        m_slot = '0;   // reference slot contents (cnt field unused)
   logic [31:0] m_cnt  = '0;   // reference bubble count
   obs_t        sb[$];         // expected outputs, one per edge

   function automatic obs_t sample();
      obs_t o;
      o.rd1 = dxif.o_DecodeExecReg_rd1;   o.rd2 = dxif.o_DecodeExecReg_rd2;
      o.imm = dxif.o_DecodeExecReg_imm;   o.pc  = dxif.o_DecodeExecReg_pc;
      o.wa  = dxif.o_DecodeExecReg_regWa; o.we  = dxif.o_DecodeExecReg_regWe;
      o.ld  = dxif.o_DecodeExecReg_isLoad; o.st = dxif.o_DecodeExecReg_isStore;
      o.op  = dxif.o_DecodeExecReg_aluOp; o.src = dxif.o_DecodeExecReg_aluSrc;
      o.valid = dxif.o_DecodeExecReg_valid;
      o.cnt = dxif.o_DecodeExecReg_bubbleCnt;
      return o;
   endfunction

   task automatic set_in(input logic [31:0] rd1, rd2, imm, pc, input logic [4:0] wa,
                         input logic we, ld, st, input logic [3:0] op, input logic src);
      dxif.i_DecodeExecReg_rd1 = rd1;     dxif.i_DecodeExecReg_rd2 = rd2;
      dxif.i_DecodeExecReg_imm = imm;     dxif.i_DecodeExecReg_pc  = pc;
      dxif.i_DecodeExecReg_regWa = wa;    dxif.i_DecodeExecReg_regWe = we;
      dxif.i_DecodeExecReg_isLoad = ld;   dxif.i_DecodeExecReg_isStore = st;
      dxif.i_DecodeExecReg_aluOp = op;    dxif.i_DecodeExecReg_aluSrc = src;
   endtask

   task automatic set_ctl(input logic r, fl, st, pa);
      rstn = r;
      dxif.i_DecodeExecReg_flush = fl;
      dxif.i_DecodeExecReg_stall = st;
      dxif.i_DecodeExecReg_pause = pa;
   endtask

   // Predict the post-edge outputs from the inputs now on the bus, push them,
   // then advance one edge and settle.
   task automatic cyc();
      obs_t e;
      logic bub;
      bub = 1'b0;
      if (!rstn) begin
         m_slot = '0; m_cnt = '0;
      end else if (dxif.i_DecodeExecReg_flush) begin
         m_slot = '0; bub = 1'b1;
      end else if (dxif.i_DecodeExecReg_stall) begin
         // hold
      end else if (dxif.i_DecodeExecReg_pause) begin
         m_slot = '0; bub = 1'b1;
      end else begin
         m_slot.rd1 = dxif.i_DecodeExecReg_rd1;  m_slot.rd2 = dxif.i_DecodeExecReg_rd2;
         m_slot.imm = dxif.i_DecodeExecReg_imm;  m_slot.pc  = dxif.i_DecodeExecReg_pc;
         m_slot.wa  = dxif.i_DecodeExecReg_regWa;
         m_slot.we  = dxif.i_DecodeExecReg_regWe & (dxif.i_DecodeExecReg_regWa != 5'd0);
         m_slot.ld  = dxif.i_DecodeExecReg_isLoad; m_slot.st = dxif.i_DecodeExecReg_isStore;
         m_slot.op  = dxif.i_DecodeExecReg_aluOp;  m_slot.src = dxif.i_DecodeExecReg_aluSrc;
         m_slot.valid = 1'b1;
      end
      if (bub && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      e = m_slot;
`ifdef DECODE_EXEC_REG_PERF_EN
      e.cnt = m_cnt;
`else
      e.cnt = 32'h0;
`endif
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t e, g;
      set_in(32'hAA, 32'hBB, 32'hCC, 32'hDD, 5'd7, 1, 1, 0, 4'h5, 1);
      set_ctl(0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         e = sb.pop_front(); g = sample(); checks++;
         if (g !== e || g.valid !== 1'b0 || g.cnt !== 32'h0) begin
            errors++; $display("FAIL reset[%0d] got=%h exp=%h", i, g, e);
         end
      end
   endtask

   task automatic test_load();
      obs_t e, g;
      set_in(32'h22, 32'h33, 32'h0, 32'h100, 5'd2, 1, 0, 0, 4'h1, 0);
      set_ctl(1, 0, 0, 0);
      cyc();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL load got=%h exp=%h", g, e); end
      checks++;
      if (g.rd1 !== 32'h22 || g.rd2 !== 32'h33 || g.wa !== 5'd2 || g.we !== 1'b1 || g.valid !== 1'b1) begin
         errors++; $display("FAIL load_fields got=%h", g);
      end
   endtask

   task automatic test_pause();
      obs_t e, g;
      logic [31:0] c0;
      c0 = m_cnt;
      set_in(32'h44, 32'h55, 32'h8, 32'h104, 5'd3, 1, 0, 0, 4'h2, 1);
      set_ctl(1, 0, 0, 1);
      cyc();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e || g.valid !== 1'b0) begin errors++; $display("FAIL pause_bubble got=%h exp=%h", g, e); end
`ifdef DECODE_EXEC_REG_PERF_EN
      checks++;
      if (g.cnt !== c0 + 1) begin errors++; $display("FAIL pause_cnt got=%h exp=%h", g.cnt, c0 + 1); end
`endif
      set_ctl(1, 0, 0, 0);
      cyc();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e || g.wa !== 5'd3 || g.valid !== 1'b1) begin
         errors++; $display("FAIL pause_reload got=%h exp=%h", g, e);
      end
   endtask

   task automatic test_stall();
      obs_t e, g;
      logic [31:0] c0;
      set_in(32'h11, 32'h1, 32'h2, 32'h108, 5'd4, 1, 0, 1, 4'h3, 0);
      set_ctl(1, 0, 0, 0);
      cyc();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL stall_pre got=%h exp=%h", g, e); end
      c0 = g.cnt;
      set_in(32'h12345678, 32'h9, 32'h9, 32'h10C, 5'd9, 1, 1, 0, 4'h7, 1);
      for (int i = 0; i < 3; i++) begin
         set_ctl(1, 0, 1, (i == 1));   // pause mid-stall must be ignored
         cyc();
         e = sb.pop_front(); g = sample(); checks++;
         if (g !== e || g.rd1 !== 32'h11 || g.cnt !== c0) begin
            errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, g, e);
         end
      end
   endtask

   task automatic test_flush_over_stall();
      obs_t e, g;
      logic [31:0] c0;
      c0 = m_cnt;
      set_ctl(1, 1, 1, 1);
      cyc();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e || g.valid !== 1'b0) begin errors++; $display("FAIL flush_stall got=%h exp=%h", g, e); end
`ifdef DECODE_EXEC_REG_PERF_EN
      checks++;
      if (g.cnt !== c0 + 1) begin errors++; $display("FAIL flush_cnt got=%h exp=%h", g.cnt, c0 + 1); end
`endif
   endtask

   task automatic test_r0();
      obs_t e, g;
      set_in(32'h5, 32'h6, 32'h7, 32'h110, 5'd0, 1, 1, 0, 4'h4, 1);
      set_ctl(1, 0, 0, 0);
      cyc();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e || g.we !== 1'b0 || g.ld !== 1'b1 || g.valid !== 1'b1) begin
         errors++; $display("FAIL r0_suppress got=%h exp=%h", g, e);
      end
   endtask

   task automatic test_reset_mid_stall();
      obs_t e, g;
      set_in(32'h77, 32'h88, 32'h99, 32'h114, 5'd6, 1, 0, 0, 4'h6, 0);
      set_ctl(1, 0, 0, 0);
      cyc();
      void'(sb.pop_front());
      set_ctl(0, 0, 1, 1);
      cyc();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e || g !== obs_t'(0)) begin errors++; $display("FAIL reset_mid_stall got=%h exp=%h", g, e); end
      set_ctl(1, 0, 0, 0);
      cyc();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e || g.rd1 !== 32'h77) begin errors++; $display("FAIL load_after_reset got=%h exp=%h", g, e); end
   endtask

   task automatic test_back_to_back();
      obs_t e, g;
      for (int i = 0; i < 60; i++) begin
         set_in($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
         set_ctl(($urandom_range(0, 19) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
         cyc();
         e = sb.pop_front(); g = sample(); checks++;
         if (g !== e) begin errors++; $display("FAIL b2b[%0d] got=%h exp=%h", i, g, e); end
      end
   endtask

   task automatic test_saturation();
      obs_t e, g;
      set_ctl(1, 0, 0, 0);
`ifdef DECODE_EXEC_REG_PERF_EN
      force dut.u_bubble_cnt.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.u_bubble_cnt.cnt_q;
      m_cnt = 32'hFFFF_FFFE;
`endif
      set_ctl(1, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         e = sb.pop_front(); g = sample(); checks++;
`ifdef DECODE_EXEC_REG_PERF_EN
         if (g !== e || g.cnt !== 32'hFFFF_FFFF) begin
`else
         if (g !== e || g.cnt !== 32'h0) begin
`endif
            errors++; $display("FAIL saturate[%0d] got=%h exp=%h", i, g, e);
         end
      end
      set_ctl(1, 0, 0, 0);
   endtask

   initial begin
      set_in('0, '0, '0, '0, '0, 0, 0, 0, '0, 0);
      set_ctl(0, 0, 0, 0);
      #1;
      test_reset();
      test_load();
      test_pause();
      test_stall();
      test_flush_over_stall();
      test_r0();
      test_reset_mid_stall();
      test_back_to_back();
      test_saturation();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
